// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_adder (with helper slice cla_4)
//  Brief    : Multi-cycle WIDTH-bit adder. One 4-bit lookahead slice is reused
//             once per clock, least-significant nibble first, with the
//             inter-nibble carry rebuilt from the slice group generate and
//             propagate outputs. Uses a start/busy/done handshake.
//  Options  : NIBBLE_SERIAL_ADDER_SUB_EN adds a 'sub' input (sum = a - b).
//  Revision : 1.0 - initial release
// ============================================================================

// 4-bit carry-lookahead slice with group generate/propagate outputs.
module cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       g_out,
    output logic       p_out
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Lookahead carries into each bit, flattened so no ripple path exists.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s     = w_p ^ w_c;
    assign g_out = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p_out = &w_p;

endmodule

// WIDTH must be a multiple of 4 and at least 8.
module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int c_NIBBLES = WIDTH / 4;
    localparam int c_IDX_W   = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NIBBLES - 1);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_s;
    logic               w_g;
    logic               w_p;
    logic               w_c_next;

    // Subtraction is folded into the operand latch: a - b = a + ~b + 1.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : c_in;
`else
    assign w_b_load   = b;
    assign w_cin_load = c_in;
`endif

    assign w_accept = (r_state == c_ST_IDLE) && start;
    assign w_last   = (r_state == c_ST_RUN) && (r_idx == c_LAST_IDX);

    assign w_a_nib  = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_nib  = r_b[{r_idx, 2'b00} +: 4];

    cla_4 u_cla (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .s     (w_s),
        .g_out (w_g),
        .p_out (w_p)
    );

    assign w_c_next = w_g | (w_p & r_carry);

    // Next-state logic: IDLE accepts a start, RUN leaves after the top nibble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_next = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_next = c_ST_IDLE;
            default:               w_state_next = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Datapath: latch operands on accept, then retire one nibble per clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= w_b_load;
                r_carry <= w_cin_load;
                r_idx   <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= w_s;
                r_carry <= w_c_next;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    // Signed overflow: carry into the MSB differs from carry out.
                    r_c_out <= w_c_next;
                    r_ovf   <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_s[3] ^ w_c_next;
                    r_done  <= 1'b1;
                    r_idx   <= '0;
                end
            end
        end
    end

    assign busy     = (r_state == c_ST_RUN);
    assign done     = r_done;
    assign sum      = r_sum;
    assign c_out    = r_c_out;
    assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Brief    : Self-checking bench for nibble_serial_adder (WIDTH=32). Expected
//             results are queued at each accepted start and compared when
//             done pulses. Sub tests compile in with NIBBLE_SERIAL_ADDER_SUB_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nibble_serial_adder;

    localparam int WIDTH = 32;
    localparam int c_LAT = WIDTH / 4 + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t             e;
        logic [WIDTH-1:0] bb;
        logic             cc;
        logic [WIDTH:0]   t;
        bb = sv ? ~bv : bv;
        cc = sv ? 1'b1 : cv;
        t  = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
        e.sum = t[WIDTH-1:0];
        e.c   = t[WIDTH];
        e.v   = (av[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != av[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("sum", 64'(sum), 64'(e.sum));
                check_val("c_out", 64'(c_out), 64'(e.c));
                check_val("overflow", 64'(overflow), 64'(e.v));
            end
        end
    end

    // Launch one operation, scramble inputs during RUN, check busy and latency.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic sv, input logic poke, input string tag);
        int cnt;
        @(negedge clk);
        a = av; b = bv; c_in = cv; sub = sv; start = 1'b1;
        exp_q.push_back(model(av, bv, cv, sv));
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        cnt = 1;
        while (done !== 1'b1 && cnt < 40) begin
            if (poke && cnt == 3) begin
                start = 1'b1;
                a     = 32'h1111_1111;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
        end
        check_val({tag, "_latency"}, 64'(cnt), 64'(c_LAT));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_sum", 64'(sum), 64'd0);
        check_val("rst_c_out", 64'(c_out), 64'd0);
        check_val("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0000_0004, 32'h0000_0002, 1'b0, 1'b0, 1'b1, "basic");
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "ripple");
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, "ovf");
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0, "pre_b2b");
        check_val("b2b_done_high", 64'(done), 64'd1);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, "b2b");

        // Reset asserted at the 4th RUN edge; no done may follow.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1111_1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_sum", 64'(sum), 64'd0);
        check_val("midrst_c_out", 64'(c_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'b0, 1'b0, "rand");
        end

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, "sub_neg");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
        run_op(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b0, 1'b0, "sub_off");
`endif

        repeat (4) @(posedge clk);
        #1;
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder that feeds one cla_4 slice and consumes its outputs: one 4-bit nibble per clock, least-significant nibble first.
- Carry between nibbles is rebuilt from the slice's g_out/p_out.
- Sits between operand registers and the ALU result mux as a small-area alternative to a full-width lookahead adder.
- Uses a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8 (N = WIDTH/4 nibbles)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
c_in  input  1  carry-in, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: sum/c_out/overflow valid
sum  output  WIDTH  result; holds until next accepted start
c_out  output  1  carry out of bit WIDTH-1
overflow  output  1  signed overflow

Behaviour:
- One clock domain; reset is synchronous and active-low.
- Reset: rst_n=0 at any rising edge forces the following, mid-operation included; the partial result is discarded.
  - state IDLE, busy=0, done=0, sum=0, c_out=0, overflow=0
  - nibble index=0, operand/carry registers=0
- States: IDLE, RUN.
- IDLE to RUN, at edge k with start=1 and rst_n=1:
  - latch a, b, c_in into internal registers
  - index=0, carry register=c_in, busy=1
- RUN, each edge k+i (i=1..N), one nibble i-1 per edge:
  - Drive the instantiated cla_4 with the registered nibble (i-1) of a and b and the carry register.
  - Write s into sum[4(i-1)+3:4(i-1)].
  - carry register <= g_out | (p_out & carry register).
  - index increments.
- Last edge (k+N):
  - also c_out <= g_out | (p_out & carry)
  - overflow <= a[W-1] ^ b[W-1] ^ s[3] ^ c_out_next, using the latched operands
  - done=1, busy=0, state IDLE
- Latency: done high for exactly the one cycle after edge k+N; N+1 edges from start sample to done visible. Throughput is one operation per N+1 cycles.
- done=0 in every other cycle.
- start while busy=1 is ignored: no queueing, latched operands unaffected.
- start in the cycle done=1 is accepted (state is IDLE): back-to-back operation.
- Input changes on a/b/c_in during RUN have no effect.
- sum nibbles update progressively during RUN and are only guaranteed valid while done=1 and after, until the next accepted start.
- c_out and overflow hold their previous values until edge k+N.
- Arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - If sub=1, the latched b is ~b and the latched carry is 1 (c_in ignored), so sum=a-b.
  - c_out=1 means no borrow; overflow is signed overflow of the subtraction.
  - If sub=0, behaviour is identical to the macro-undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- Basic add: a=0x00000004, b=0x00000002, c_in=0, start pulsed → done exactly 9 cycles after the start edge; sum=0x00000006, c_out=0, overflow=0.
- Full carry ripple:
  - a=0xFFFFFFFF, b=0x00000000, c_in=1 → sum=0x00000000, c_out=1, overflow=0.
  - a=0x7FFFFFFF, b=0x00000001, c_in=0 → sum=0x80000000, c_out=0, overflow=1.
- Handshake:
  - start re-pulsed with a=0x11111111 while busy=1 → ignored; first result 0x00000006 unchanged.
  - start held high during the done cycle with a=0x10, b=0x20 → accepted; next done gives sum=0x00000030.
- Reset mid-operation: rst_n low at the 4th RUN edge of a=0x12345678 + b=0x11111111 → busy=0, done=0, sum=0 next cycle; no done pulse follows. A new start then yields a correct result.
- With NIBBLE_SERIAL_ADDER_SUB_EN:
  - sub=1, a=5, b=7 → sum=0xFFFFFFFE, c_out=0, overflow=0.
  - sub=1, a=0x80000000, b=1 → sum=0x7FFFFFFF, c_out=1, overflow=1.
